// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default Avalon widths for the uart arbiter
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } uart_arb_state_t;

    localparam int UART_AAW = 1;
    localparam int UART_ADW = 32;
    localparam int UART_ABW = UART_ADW / 8;

    // Width of a master index; never zero so a single-master build still elaborates.
    function automatic int uart_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_arb_rr.sv
// rtl/uart_arb_rr.sv - combinational round-robin picker, searches last+1, last+2, ... with wrap
module uart_arb_rr
    import uart_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = uart_idx_w(NM)
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [NM-1:0] pick_o,
    output logic [IW-1:0] pick_idx_o,
    output logic          valid_o
);

    int   idx;
    logic found;

    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NM; k++) begin
            idx = (int'(last_i) + k) % NM;
            for (int i = 0; i < NM; i++) begin
                if (!found && (i == idx) && req_i[i]) begin
                    found         = 1'b1;
                    pick_o[i]     = 1'b1;
                    pick_idx_o    = IW'(i);
                end
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/uart_avalon_arbiter.sv
// rtl/uart_avalon_arbiter.sv - round-robin share of one uart Avalon slave among NM masters
// Optional UART_ARB_LOCK_EN adds mst_lock for back-to-back transfers without an idle bubble.
module uart_avalon_arbiter
    import uart_pkg::*;
#(
    parameter int NM  = 2,
    parameter int AAW = UART_AAW,
    parameter int ADW = UART_ADW,
    parameter int ABW = ADW / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NM-1:0]     mst_read,
    input  logic [NM-1:0]     mst_write,
    input  logic [NM*AAW-1:0] mst_address,
    input  logic [NM*ABW-1:0] mst_byteenable,
    input  logic [NM*ADW-1:0] mst_writedata,
`ifdef UART_ARB_LOCK_EN
    input  logic [NM-1:0]     mst_lock,
`endif
    output logic [ADW-1:0]    mst_readdata,
    output logic [NM-1:0]     mst_waitrequest,
    output logic              avalon_read,
    output logic              avalon_write,
    output logic [AAW-1:0]    avalon_address,
    output logic [ABW-1:0]    avalon_byteenable,
    output logic [ADW-1:0]    avalon_writedata,
    input  logic [ADW-1:0]    avalon_readdata,
    input  logic              avalon_waitrequest,
    output logic [NM-1:0]     grant
);

    localparam int IW = uart_idx_w(NM);

    uart_arb_state_t state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NM-1:0]   req, pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            owner_req, owner_lock, done;

    assign req = mst_read | mst_write;

    uart_arb_rr #(
        .NM (NM),
        .IW (IW)
    ) u_rr (
        .req_i      (req),
        .last_i     (last_q),
        .pick_o     (pick),
        .pick_idx_o (pick_idx),
        .valid_o    (pick_valid)
    );

    // grant_q is non-zero only in BUSY, so an empty grant leaves the slave port idle.
    always_comb begin
        avalon_read       = 1'b0;
        avalon_write      = 1'b0;
        avalon_address    = '0;
        avalon_byteenable = '0;
        avalon_writedata  = '0;
        mst_waitrequest   = '1;
        owner_req         = 1'b0;
        owner_lock        = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (grant_q[i]) begin
                avalon_read        = mst_read[i];
                avalon_write       = mst_write[i];
                avalon_address     = mst_address[i*AAW +: AAW];
                avalon_byteenable  = mst_byteenable[i*ABW +: ABW];
                avalon_writedata   = mst_writedata[i*ADW +: ADW];
                mst_waitrequest[i] = avalon_waitrequest;
                owner_req          = req[i];
`ifdef UART_ARB_LOCK_EN
                owner_lock         = mst_lock[i];
`endif
            end
        end
    end

    assign done         = (avalon_read | avalon_write) & ~avalon_waitrequest;
    assign mst_readdata = avalon_readdata;
    assign grant        = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = pick;
                    last_d  = pick_idx;
                end
            end
            BUSY: begin
                // A locked owner that is still requesting keeps the port across completions.
                if (!owner_req || (done && !owner_lock)) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_avalon_arbiter.sv
// tb/tb_uart_avalon_arbiter.sv - directed and randomized check of uart_avalon_arbiter against an owner-based model
module tb_uart_avalon_arbiter;

    localparam int NM  = 3;
    localparam int AAW = 2;
    localparam int ADW = 32;
    localparam int ABW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     mst_read = '0;
    logic [NM-1:0]     mst_write = '0;
    logic [NM*AAW-1:0] mst_address = '0;
    logic [NM*ABW-1:0] mst_byteenable = '0;
    logic [NM*ADW-1:0] mst_writedata = '0;
    logic [NM-1:0]     mst_lock = '0;
    logic [ADW-1:0]    mst_readdata;
    logic [NM-1:0]     mst_waitrequest;
    logic              avalon_read, avalon_write;
    logic [AAW-1:0]    avalon_address;
    logic [ABW-1:0]    avalon_byteenable;
    logic [ADW-1:0]    avalon_writedata;
    logic [ADW-1:0]    avalon_readdata = '0;
    logic              avalon_waitrequest = 1'b0;
    logic [NM-1:0]     grant;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_avalon_arbiter #(.NM(NM), .AAW(AAW), .ADW(ADW), .ABW(ABW)) dut (
        .clk                (clk),
        .rst                (rst),
        .mst_read           (mst_read),
        .mst_write          (mst_write),
        .mst_address        (mst_address),
        .mst_byteenable     (mst_byteenable),
        .mst_writedata      (mst_writedata),
`ifdef UART_ARB_LOCK_EN
        .mst_lock           (mst_lock),
`endif
        .mst_readdata       (mst_readdata),
        .mst_waitrequest    (mst_waitrequest),
        .avalon_read        (avalon_read),
        .avalon_write       (avalon_write),
        .avalon_address     (avalon_address),
        .avalon_byteenable  (avalon_byteenable),
        .avalon_writedata   (avalon_writedata),
        .avalon_readdata    (avalon_readdata),
        .avalon_waitrequest (avalon_waitrequest),
        .grant              (grant)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [ADW-1:0] d);
        mst_writedata[i*ADW +: ADW] = d;
    endtask

    // Directed log of completed writes observed on the uart side.
    int             log_m[$];
    logic [ADW-1:0] log_d[$];
    int             log_c[$];

    task automatic log_clear();
        log_m.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic obs();
        if (avalon_write && !avalon_waitrequest) begin
            for (int i = 0; i < NM; i++) begin
                if (grant[i]) begin
                    log_m.push_back(i);
                    log_d.push_back(avalon_writedata);
                    log_c.push_back(cyc);
                end
            end
        end
    endtask

    // Reference model: who owns the port (-1 = nobody) and who was served last.
    int            owner = -1;
    int            mlast = NM - 1;
    logic [NM-1:0] rq, eg, ew;
    int            c;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            rq = mst_read | mst_write;
            if (owner < 0) begin
                chk("m_grant", grant, '0);
                chk("m_av_read", avalon_read, 1'b0);
                chk("m_av_write", avalon_write, 1'b0);
                chk("m_waitreq", mst_waitrequest, {NM{1'b1}});
            end else begin
                eg = '0;
                eg[owner] = 1'b1;
                ew = '1;
                ew[owner] = avalon_waitrequest;
                chk("m_grant", grant, eg);
                chk("m_av_read", avalon_read, mst_read[owner]);
                chk("m_av_write", avalon_write, mst_write[owner]);
                chk("m_av_addr", avalon_address, mst_address[owner*AAW +: AAW]);
                chk("m_av_be", avalon_byteenable, mst_byteenable[owner*ABW +: ABW]);
                chk("m_av_wdata", avalon_writedata, mst_writedata[owner*ADW +: ADW]);
                chk("m_waitreq", mst_waitrequest, ew);
            end
            chk("m_readdata", mst_readdata, avalon_readdata);

            if (rst) begin
                owner = -1;
                mlast = NM - 1;
            end else if (owner < 0) begin
                for (int k = 1; k <= NM; k++) begin
                    c = (mlast + k) % NM;
                    if (owner < 0 && rq[c]) owner = c;
                end
                if (owner >= 0) mlast = owner;
            end else if (!rq[owner]) begin
                owner = -1;
            end else if ((mst_read[owner] || mst_write[owner]) && !avalon_waitrequest) begin
`ifdef UART_ARB_LOCK_EN
                if (!mst_lock[owner]) owner = -1;
`else
                owner = -1;
`endif
            end
        end
    end

    logic [7:0]    str [6] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c};
    int            n, idx;
    logic [NM-1:0] pend;
    logic          d0, d1, got1;

    initial begin
        mst_byteenable = '1;
        repeat (3) tick();
        chk("rst_grant", grant, 3'b000);
        chk("rst_waitreq", mst_waitrequest, 3'b111);
        chk("rst_av_write", avalon_write, 1'b0);
        chk("rst_av_read", avalon_read, 1'b0);
        avalon_readdata = 32'hCAFE_0001;
        #1;
        chk("rst_readdata", mst_readdata, 32'hCAFE_0001);
        rst = 1'b0;
        tick();

        // Master 0 writes 'H'
        mst_write = 3'b001;
        set_wd(0, 32'h48);
        #1;
        chk("t1_idle_grant", grant, 3'b000);
        chk("t1_idle_write", avalon_write, 1'b0);
        tick();
        chk("t1_grant", grant, 3'b001);
        chk("t1_write", avalon_write, 1'b1);
        chk("t1_wdata", avalon_writedata, 32'h48);
        chk("t1_waitreq", mst_waitrequest, 3'b110);
        mst_write = 3'b000;
        tick();
        chk("t1_rel_grant", grant, 3'b000);
        chk("t1_rel_write", avalon_write, 1'b0);

        // Two masters write continuously: B first (last=0), then alternate
        mst_write = 3'b011;
        set_wd(0, 32'h41);
        set_wd(1, 32'h42);
        log_clear();
        n = 0;
        while (log_m.size() < 6 && n < 30) begin
            tick();
            obs();
            n++;
        end
        chk("t2_cycles", n, 11);
        for (int i = 0; i < 6 && i < log_m.size(); i++) begin
            chk("t2_order", log_m[i], (i % 2 == 0) ? 1 : 0);
            chk("t2_data", log_d[i], (i % 2 == 0) ? 32'h42 : 32'h41);
        end
        tick();
        mst_write = 3'b000;
        tick();

        // uart stalls master 1 for several cycles
        avalon_waitrequest = 1'b1;
        mst_write = 3'b011;
        set_wd(0, 32'h31);
        set_wd(1, 32'h32);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_grant", grant, 3'b010);
            chk("t3_waitreq", mst_waitrequest, 3'b111);
            chk("t3_wdata", avalon_writedata, 32'h32);
            if (k < 4) tick();
        end
        avalon_waitrequest = 1'b0;
        #1;
        chk("t3_release", mst_waitrequest, 3'b101);
        tick();
        mst_write = 3'b001;
        tick();
        chk("t3_next_grant", grant, 3'b001);
        chk("t3_next_waitreq", mst_waitrequest, 3'b110);
        tick();
        mst_write = 3'b000;
        tick();

        // All three request at once after last=0 -> 1, 2, 0
        mst_write = 3'b111;
        set_wd(0, 32'h61);
        set_wd(1, 32'h62);
        set_wd(2, 32'h63);
        log_clear();
        pend = '0;
        n = 0;
        while (mst_write != 0 && n < 30) begin
            tick();
            mst_write = mst_write & ~pend;
            #1;
            obs();
            pend = mst_write & ~mst_waitrequest;
            n++;
        end
        chk("t4_count", log_m.size(), 3);
        if (log_m.size() == 3) begin
            chk("t4_first", log_m[0], 1);
            chk("t4_second", log_m[1], 2);
            chk("t4_third", log_m[2], 0);
            chk("t4_third_data", log_d[2], 32'h61);
        end
        mst_write = 3'b000;
        tick();

        // Reset in the middle of a transfer
        avalon_waitrequest = 1'b1;
        mst_write = 3'b001;
        set_wd(0, 32'h55);
        tick();
        chk("t5_busy_grant", grant, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_grant", grant, 3'b000);
        chk("t5_write", avalon_write, 1'b0);
        chk("t5_waitreq", mst_waitrequest, 3'b111);
        tick();
        chk("t5_regrant", grant, 3'b001);
        avalon_waitrequest = 1'b0;
        tick();
        mst_write = 3'b000;
        tick();

`ifdef UART_ARB_LOCK_EN
        // Locked "Hello," from master 0 while master 1 keeps requesting
        mst_write = 3'b001;
        mst_lock = 3'b001;
        set_wd(0, 32'(str[0]));
        tick();
        mst_write[1] = 1'b1;
        set_wd(1, 32'h42);
        log_clear();
        idx = 0;
        got1 = 1'b0;
        for (int k = 0; k < 40 && !got1; k++) begin
            set_wd(0, (idx < 6) ? 32'(str[idx]) : 32'h0);
            mst_lock[0] = (idx < 5);
            mst_write[0] = (idx < 6);
            #1;
            obs();
            d0 = grant[0] && avalon_write && !avalon_waitrequest;
            d1 = grant[1] && avalon_write && !avalon_waitrequest;
            tick();
            if (d0) idx++;
            if (d1) begin
                mst_write[1] = 1'b0;
                got1 = 1'b1;
            end
        end
        chk("t6_count", log_m.size(), 7);
        if (log_m.size() == 7) begin
            for (int i = 0; i < 6; i++) begin
                chk("t6_owner", log_m[i], 0);
                chk("t6_char", log_d[i], 32'(str[i]));
            end
            chk("t6_no_bubble", log_c[5] - log_c[0], 5);
            chk("t6_then_m1", log_m[6], 1);
        end
        mst_write = '0;
        mst_lock = '0;
        tick();
`endif

        // Randomized traffic, occasional reset, checked by the model every cycle
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) begin
                mst_read  = NM'($urandom);
                mst_write = NM'($urandom);
            end
            mst_address        = (NM*AAW)'($urandom);
            mst_byteenable     = (NM*ABW)'($urandom);
            mst_writedata      = {$urandom, $urandom, $urandom};
            mst_lock           = NM'($urandom);
            avalon_readdata    = $urandom;
            avalon_waitrequest = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 1'b0;
        mst_read = '0;
        mst_write = '0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
